// File: rtl/booth_seq_mul.sv
// Sequential radix-4 Booth multiplier that retires one Booth digit per clock.
// Operands are widened by two bits so signed and unsigned modes share one datapath.
module booth_seq_mul #(
   parameter int WIDTH = 32
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int E    = WIDTH + 2;
   localparam int ITER = E / 2;
   localparam int CW   = $clog2(ITER);
   localparam int AW   = 2 * E + 3;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             r_state;
   logic [E+1:0]       r_pHi;
   logic [E+1:0]       r_m;
   logic [E-1:0]       r_q;
   logic               r_qm1;
   logic [CW-1:0]      r_cnt;
   logic               r_done;
   logic [2*WIDTH-1:0] r_product;

   logic                 w_extA;
   logic                 w_extB;
   logic                 w_last;
   logic [E+1:0]         w_addend;
   logic [E+1:0]         w_sum;
   logic signed [AW-1:0] w_accIn;
   logic signed [AW-1:0] w_accOut;

   // Extension bit is the operand MSB only in signed mode, so unsigned values stay positive.
   assign w_extA = is_signed & multiplicand[WIDTH-1];
   assign w_extB = is_signed & multiplier[WIDTH-1];
   assign w_last = (r_cnt == CW'(ITER - 1));

   always_comb begin
      w_addend = '0;
      case ({r_q[1:0], r_qm1})
         3'b001, 3'b010: w_addend = r_m;
         3'b011:         w_addend = {r_m[E:0], 1'b0};
         3'b100:         w_addend = -{r_m[E:0], 1'b0};
         3'b101, 3'b110: w_addend = -r_m;
         default:        w_addend = '0;
      endcase
   end

   assign w_sum    = r_pHi + w_addend;
   assign w_accIn  = {w_sum, r_q, r_qm1};
   assign w_accOut = w_accIn >>> 2;

   // A start is accepted in IDLE or DONE; RUN retires one digit per edge and ignores start.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state   <= IDLE;
         r_pHi     <= '0;
         r_m       <= '0;
         r_q       <= '0;
         r_qm1     <= 1'b0;
         r_cnt     <= '0;
         r_done    <= 1'b0;
         r_product <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_state != RUN && start) begin
            r_state <= RUN;
            r_pHi   <= '0;
            r_m     <= {{4{w_extA}}, multiplicand};
            r_q     <= {{2{w_extB}}, multiplier};
            r_qm1   <= 1'b0;
            r_cnt   <= '0;
         end else if (r_state == RUN) begin
            r_pHi <= w_accOut[AW-1:E+1];
            r_q   <= w_accOut[E:1];
            r_qm1 <= w_accOut[0];
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
               r_state   <= DONE;
               r_done    <= 1'b1;
               r_product <= w_accOut[2*WIDTH:1];
            end
         end else begin
            r_state <= IDLE;
         end
      end
   end

   assign busy    = (r_state == RUN);
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: doc/booth_seq_mul.md
# booth_seq_mul

Parametrised, sequential radix-4 (bit-pair) Booth multiplier with a start/done handshake and selectable signed or unsigned operation. It is the multi-cycle successor to the combinational bit-pair multiplier and feeds the MUL path of the ALU. It trades latency for area: one Booth digit is retired per clock instead of a full combinational partial-product array.

## Interface
- WIDTH, 32, operand width in bits; must be even and ≥ 4.
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled on rising edge, accepted only in IDLE or DONE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched with operands.
- multiplicand  in  WIDTH  operand A; latched on accepted start.
- multiplier  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; product valid in this cycle.
- product  out  2*WIDTH  result register; holds until the next completion.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → latch, go to RUN.
  - RUN: count ITER digits, then go to DONE.
  - DONE: start=1 → latch, go to RUN (back-to-back); otherwise go to IDLE.
- Internal width E = WIDTH+2. Both operands are extended to E bits: sign-extended if is_signed=1, zero-extended if 0. Both modes share one datapath.
- ITER = E/2 = WIDTH/2+1 digits (17 for WIDTH=32).
- Accumulator layout: {P_hi[E+1:0], Q[E-1:0], q_-1}.
  - On load: P_hi=0, Q=extended multiplier, q_-1=0, digit counter=0.
- Each RUN cycle: examine {Q[1],Q[0],q_-1} and select 0, ±M, or ±2M, where M is the extended multiplicand sign-extended to E+2 bits.
  - 000/111 → 0; 001/010 → +M; 011 → +2M; 100 → −2M; 101/110 → −M.
  - Add the selected value to P_hi, then arithmetic-shift the whole accumulator right by 2.
- On the final digit, product ← low 2*WIDTH bits of {P_hi,Q} after the final shift. This is exact for both modes.
- start is ignored while busy=1. Operand and is_signed inputs are don't-care except on an accepted start edge.
- busy is combinational from state. done is registered, high exactly while state=DONE.
- Arithmetic is exact modulo 2^(2*WIDTH); no overflow is possible.

## Timing
- Reset (clear=1, async): state=IDLE; busy=0, done=0, product=0; counter and accumulator cleared.
  - Applies immediately, including mid-RUN. The operation in progress is abandoned and no done is produced.
- clear deasserted: the first possible accepted start is on the next rising edge.
- Latency: start accepted at edge k → busy=1 from k until edge k+ITER. At edge k+ITER: done=1, busy=0, product updated. done falls at edge k+ITER+1.
  - For WIDTH=32, done rises 17 cycles after the start edge.
- Throughput with back-to-back starts: one result per ITER+1 cycles. The start sampled while done=1 is accepted, so done pulses every 18 cycles for WIDTH=32.
- product changes only at a completion edge or on clear. During RUN it holds the previous result.

## Test plan
- WIDTH=32, signed, 15×3 → done after 17 cycles, product=0x0000_0000_0000_002D, single-cycle done pulse.
- Signed −7×5 (0xFFFFFFF9, 0x00000005) → product=0xFFFF_FFFF_FFFF_FFDD. Signed −12×−4 → 0x0000_0000_0000_0030.
- 0xFFFFFFFF×0xFFFFFFFF: unsigned → 0xFFFF_FFFE_0000_0001; signed → 0x0000_0000_0000_0001. Signed 0x80000000×0x80000000 → 0x4000_0000_0000_0000.
- Start pulsed during cycles 3–10 of a RUN with different operands → ignored; first result correct, busy stays high. Start held high through DONE → second operation begins, done pulses 18 cycles apart.
- clear asserted mid-RUN (cycle 8) → busy/done/product=0 asynchronously, no done pulse. A new start after release yields the correct result.
- WIDTH=8 instance, 1000 random signed and unsigned pairs → product matches the reference model (A*B mod 2^16). Done latency is exactly 5 cycles each time.
